// File: rtl/hwag_sync_ctrl.sv
// hwag_sync_ctrl
//   Crank-wheel synchronisation controller. Watches the capture strobe and
//   gap/period flags coming out of the tooth/gap datapath and runs a
//   four-state machine (IDLE, SEARCH, VERIFY, SYNC) that first acquires the
//   missing-tooth gap, confirms it over a full revolution, then tracks it
//   while tolerating up to LOSS_MAX-1 consecutive gap errors.
//
// Parameters
//   TW        tooth counter width
//   LOSS_MAX  consecutive gap errors that drop sync (1..15)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   ena        capture enable; 0 forces IDLE (highest priority)
//   cap_vld    one-cycle strobe per captured VR edge
//   gap        gap detected on the latest captures (valid with cap_vld)
//   pmin_ok    captured periods above minimum (valid with cap_vld)
//   pmax_ok    captured periods below maximum (valid with cap_vld)
//   pcnt_ovf   period counter overflow pulse (stall)
//   tooth_top  last tooth index per revolution (edges per rev - 1)
//   state      IDLE=0, SEARCH=1, VERIFY=2, SYNC=3
//   sync       high only in SYNC
//   tooth      edges since last gap, 0 on first edge after the gap
//   rev        one-cycle pulse on each accepted gap in SYNC / SYNC entry
//   sync_lost  one-cycle pulse on leaving VERIFY or SYNC for SEARCH
//   err_cnt    consecutive gap errors, saturating at 15

module hwag_sync_ctrl #(
  parameter int unsigned TW       = 8,
  parameter int unsigned LOSS_MAX = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          cap_vld,
  input  logic          gap,
  input  logic          pmin_ok,
  input  logic          pmax_ok,
  input  logic          pcnt_ovf,
  input  logic [TW-1:0] tooth_top,
  output logic [1:0]    state,
  output logic          sync,
  output logic [TW-1:0] tooth,
  output logic          rev,
  output logic          sync_lost,
  output logic [3:0]    err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    SYNC   = 2'd3
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tooth;
  logic [3:0]    r_err;
  logic          r_sync;
  logic          r_rev;
  logic          r_lost;

  state_t        w_state_nxt;
  logic [TW-1:0] w_tooth_nxt;
  logic [3:0]    w_err_nxt;
  logic          w_rev_nxt;
  logic          w_lost_nxt;

  logic          w_top_ok;
  logic          w_below;
  logic          w_at_top;
  logic          w_advance;
  logic          w_gap_hit;
  logic          w_per_ok;
  logic [3:0]    w_err_inc;
  logic          w_err_trip;
  logic [TW-1:0] w_tooth_inc;

  // A wheel with fewer than three edges per revolution cannot be acquired.
  assign w_top_ok    = (tooth_top >= TW'(2));
  assign w_below     = (r_tooth < tooth_top);
  assign w_at_top    = (r_tooth == tooth_top);
  assign w_advance   = !gap && w_below;
  assign w_gap_hit   = gap && w_at_top;
  assign w_per_ok    = pmin_ok && pmax_ok;
  assign w_tooth_inc = r_tooth + TW'(1);
  assign w_err_inc   = (r_err == 4'hF) ? r_err : (r_err + 4'd1);
  assign w_err_trip  = (32'(w_err_inc) >= LOSS_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_tooth_nxt = r_tooth;
    w_err_nxt   = r_err;
    w_rev_nxt   = 1'b0;
    w_lost_nxt  = 1'b0;

    if (!ena) begin
      w_state_nxt = IDLE;
      w_tooth_nxt = '0;
      w_err_nxt   = '0;
    end else if (pcnt_ovf && (r_state != IDLE)) begin
      w_state_nxt = SEARCH;
      w_tooth_nxt = '0;
      w_err_nxt   = '0;
      w_lost_nxt  = (r_state == VERIFY) || (r_state == SYNC);
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = SEARCH;
        end
        SEARCH: begin
          if (cap_vld && gap && w_per_ok && w_top_ok) begin
            w_state_nxt = VERIFY;
            w_tooth_nxt = '0;
          end
        end
        VERIFY: begin
          if (cap_vld) begin
            if (w_advance) begin
              w_tooth_nxt = w_tooth_inc;
            end else if (w_gap_hit) begin
              w_state_nxt = SYNC;
              w_tooth_nxt = '0;
              w_rev_nxt   = 1'b1;
            end else if (gap && w_per_ok) begin
              // Plausible gap at the wrong position: restart the count here.
              w_tooth_nxt = '0;
            end else begin
              w_state_nxt = SEARCH;
              w_tooth_nxt = '0;
              w_lost_nxt  = 1'b1;
            end
          end
        end
        SYNC: begin
          if (cap_vld) begin
            if (w_advance) begin
              w_tooth_nxt = w_tooth_inc;
            end else if (w_gap_hit) begin
              w_tooth_nxt = '0;
              w_err_nxt   = '0;
              w_rev_nxt   = 1'b1;
            end else if (w_err_trip) begin
              w_state_nxt = SEARCH;
              w_tooth_nxt = '0;
              w_err_nxt   = '0;
              w_lost_nxt  = 1'b1;
            end else begin
              // Missing gap becomes a phantom gap, early gap realigns.
              w_tooth_nxt = '0;
              w_err_nxt   = w_err_inc;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_tooth <= '0;
      r_err   <= '0;
      r_sync  <= 1'b0;
      r_rev   <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tooth <= w_tooth_nxt;
      r_err   <= w_err_nxt;
      r_sync  <= (w_state_nxt == SYNC);
      r_rev   <= w_rev_nxt;
      r_lost  <= w_lost_nxt;
    end
  end

  assign state     = r_state;
  assign sync      = r_sync;
  assign tooth     = r_tooth;
  assign rev       = r_rev;
  assign sync_lost = r_lost;
  assign err_cnt   = r_err;

endmodule

// File: tb/tb_hwag_sync_ctrl.sv
module tb_hwag_sync_ctrl;

  localparam int unsigned TW       = 8;
  localparam int unsigned LOSS_MAX = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          cap_vld;
  logic          gap;
  logic          pmin_ok;
  logic          pmax_ok;
  logic          pcnt_ovf;
  logic [TW-1:0] tooth_top;
  logic [1:0]    state;
  logic          sync;
  logic [TW-1:0] tooth;
  logic          rev;
  logic          sync_lost;
  logic [3:0]    err_cnt;

  hwag_sync_ctrl #(.TW(TW), .LOSS_MAX(LOSS_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .cap_vld   (cap_vld),
    .gap       (gap),
    .pmin_ok   (pmin_ok),
    .pmax_ok   (pmax_ok),
    .pcnt_ovf  (pcnt_ovf),
    .tooth_top (tooth_top),
    .state     (state),
    .sync      (sync),
    .tooth     (tooth),
    .rev       (rev),
    .sync_lost (sync_lost),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: mode 0 idle, 1 hunting for a gap, 2 confirming a
  // revolution, 3 locked.
  int m_mode  = 0;
  int m_tooth = 0;
  int m_err   = 0;
  int m_rev   = 0;
  int m_lost  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int e, input int cv, input int g, input int pmn,
                            input int pmx, input int ov, input int top);
    int t;
    m_rev  = 0;
    m_lost = 0;
    if (e == 0) begin
      m_mode = 0; m_tooth = 0; m_err = 0;
      return;
    end
    if (m_mode == 0) begin
      m_mode = 1;
      return;
    end
    if (ov != 0) begin
      m_lost  = (m_mode >= 2) ? 1 : 0;
      m_mode  = 1; m_tooth = 0; m_err = 0;
      return;
    end
    if (cv == 0) return;
    t = m_tooth;
    if (m_mode == 1) begin
      if (g != 0 && pmn != 0 && pmx != 0 && top >= 2) begin
        m_mode = 2; m_tooth = 0;
      end
      return;
    end
    if (g == 0 && t < top) begin
      m_tooth = t + 1;
      return;
    end
    if (g != 0 && t == top) begin
      m_mode = 3; m_tooth = 0; m_err = 0; m_rev = 1;
      return;
    end
    m_tooth = 0;
    if (m_mode == 2) begin
      if (!(g != 0 && pmn != 0 && pmx != 0)) begin
        m_mode = 1; m_lost = 1;
      end
    end else begin
      m_err = (m_err + 1 > 15) ? 15 : m_err + 1;
      if (m_err >= LOSS_MAX) begin
        m_mode = 1; m_err = 0; m_lost = 1;
      end
    end
  endtask

  task automatic compare();
    chk("state", int'(state), m_mode);
    chk("sync", int'(sync), (m_mode == 3) ? 1 : 0);
    chk("tooth", int'(tooth), m_tooth);
    chk("err_cnt", int'(err_cnt), m_err);
    chk("rev", int'(rev), m_rev);
    chk("sync_lost", int'(sync_lost), m_lost);
    chk("rev_and_lost", int'(rev & sync_lost), 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(int'(ena), int'(cap_vld), int'(gap), int'(pmin_ok), int'(pmax_ok),
               int'(pcnt_ovf), int'(tooth_top));
    @(negedge clk);
    compare();
  endtask

  task automatic strobe(input logic g, input logic pmn, input logic pmx);
    cap_vld = 1'b1; gap = g; pmin_ok = pmn; pmax_ok = pmx;
    cycle();
    cap_vld = 1'b0; gap = 1'b0; pmin_ok = 1'b1; pmax_ok = 1'b1;
  endtask

  task automatic normals(input int n);
    for (int i = 0; i < n; i++) begin
      strobe(1'b0, 1'b1, 1'b1);
      cycle();
    end
  endtask

  // Gap, a full revolution of normal edges, then the confirming gap.
  task automatic acquire();
    strobe(1'b1, 1'b1, 1'b1);
    cycle();
    normals(57);
    strobe(1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int phys;
    rst = 1'b0; ena = 1'b0; cap_vld = 1'b0; gap = 1'b0;
    pmin_ok = 1'b1; pmax_ok = 1'b1; pcnt_ovf = 1'b0; tooth_top = 8'd57;

    @(negedge clk);
    @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_sync", int'(sync), 0);
    chk("rst_tooth", int'(tooth), 0);
    chk("rst_rev", int'(rev), 0);
    chk("rst_lost", int'(sync_lost), 0);
    chk("rst_err", int'(err_cnt), 0);

    rst = 1'b1;
    cycle();
    ena = 1'b1;
    cycle();
    chk("ena_to_search", int'(state), 1);

    // Clean acquisition on a 60-2 wheel.
    strobe(1'b1, 1'b1, 1'b1);
    chk("acq_verify", int'(state), 2);
    cycle();
    normals(57);
    chk("acq_tooth57", int'(tooth), 57);
    strobe(1'b1, 1'b1, 1'b1);
    chk("acq_sync_state", int'(state), 3);
    chk("acq_rev", int'(rev), 1);
    chk("acq_sync", int'(sync), 1);
    cycle();
    chk("acq_rev_pulse", int'(rev), 0);
    normals(57);
    strobe(1'b1, 1'b1, 1'b1);
    chk("rev_58_strobes", int'(rev), 1);
    chk("tooth_wrap", int'(tooth), 0);
    cycle();

    // Single missing gap is tolerated.
    normals(57);
    strobe(1'b0, 1'b1, 1'b1);
    chk("miss_tooth", int'(tooth), 0);
    chk("miss_err", int'(err_cnt), 1);
    chk("miss_sync", int'(sync), 1);
    chk("miss_norev", int'(rev), 0);
    cycle();
    normals(57);
    strobe(1'b1, 1'b1, 1'b1);
    chk("recover_err", int'(err_cnt), 0);
    chk("recover_rev", int'(rev), 1);
    cycle();

    // Early gap then missing gap drops sync.
    normals(30);
    chk("early_at30", int'(tooth), 30);
    strobe(1'b1, 1'b1, 1'b1);
    chk("early_err", int'(err_cnt), 1);
    chk("early_tooth", int'(tooth), 0);
    cycle();
    normals(57);
    strobe(1'b0, 1'b1, 1'b1);
    chk("two_err_lost", int'(sync_lost), 1);
    chk("two_err_state", int'(state), 1);
    chk("two_err_sync", int'(sync), 0);
    chk("two_err_err", int'(err_cnt), 0);
    cycle();

    // Stall in SYNC, then in SEARCH.
    acquire();
    cycle();
    normals(12);
    pcnt_ovf = 1'b1;
    cycle();
    chk("stall_state", int'(state), 1);
    chk("stall_lost", int'(sync_lost), 1);
    chk("stall_tooth", int'(tooth), 0);
    cycle();
    chk("stall_lost_1cyc", int'(sync_lost), 0);
    pcnt_ovf = 1'b0;
    cycle();
    chk("stall_search_nolost", int'(sync_lost), 0);

    // Period limits.
    strobe(1'b1, 1'b1, 1'b0);
    chk("pmax_ignored", int'(state), 1);
    cycle();
    strobe(1'b1, 1'b1, 1'b1);
    chk("verify_again", int'(state), 2);
    cycle();
    normals(57);
    pcnt_ovf = 1'b1;
    strobe(1'b1, 1'b1, 1'b1);
    pcnt_ovf = 1'b0;
    chk("ovf_beats_gap", int'(state), 1);
    chk("ovf_no_rev", int'(rev), 0);
    cycle();

    // Enable drop mid-SYNC.
    acquire();
    cycle();
    normals(5);
    ena = 1'b0;
    cycle();
    chk("ena_idle", int'(state), 0);
    chk("ena_nolost", int'(sync_lost), 0);
    chk("ena_tooth", int'(tooth), 0);
    ena = 1'b1;
    cycle();

    // Asynchronous reset between edges.
    acquire();
    cycle();
    normals(7);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_sync", int'(sync), 0);
    chk("arst_tooth", int'(tooth), 0);
    chk("arst_err", int'(err_cnt), 0);
    m_mode = 0; m_tooth = 0; m_err = 0; m_rev = 0; m_lost = 0;
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // Too few teeth per revolution: never leaves SEARCH.
    tooth_top = 8'd1;
    strobe(1'b1, 1'b1, 1'b1);
    chk("top_lt2", int'(state), 1);
    cycle();

    // Randomized run on a small wheel with sporadic faults.
    tooth_top = 8'd9;
    phys = 0;
    for (int c = 0; c < 6000; c++) begin
      ena      = ($urandom_range(0, 499) != 0);
      pcnt_ovf = ($urandom_range(0, 299) == 0);
      cap_vld  = ($urandom_range(0, 2) == 0);
      pmin_ok  = ($urandom_range(0, 24) != 0);
      pmax_ok  = ($urandom_range(0, 24) != 0);
      if (cap_vld) begin
        gap  = (phys == 9);
        if ($urandom_range(0, 39) == 0) gap = ~gap;
        phys = (phys == 9) ? 0 : phys + 1;
      end else begin
        gap = 1'($urandom_range(0, 1));
      end
      cycle();
    end
    cap_vld = 1'b0; pcnt_ovf = 1'b0; ena = 1'b1;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
